mode7_exp_sum: RTL and testbench
================================

MODE7_EXP_SUM -- requirements
Module: mode7_exp_sum

Interface
REQ-001 SHALL have parameter NUM, default 4, lanes per beat (matches the four mode7_exp outputs).
REQ-002 SHALL have parameter DATAWIDTH, default 16, lane width; each lane is an unsigned Q4.12 exp value.
REQ-003 SHALL have parameter BEATS_PER_ROW, default 8, beats per softmax row (32 words / 4 lanes).
REQ-004 SHALL have parameter ACC_WIDTH, default 24, accumulator and result width in Q12.12.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port clear, input, 1 bit: synchronous abort of the current row.
REQ-009 SHALL have ports inp0..inp3, input, DATAWIDTH each: exp lane values.
REQ-010 SHALL have port in_valid, input, 1 bit: lanes valid this cycle.
REQ-011 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-012 SHALL have port row_sum, output, ACC_WIDTH: sum of all lanes of one row.
REQ-013 SHALL have port out_valid, output, 1 bit: row_sum valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer takes row_sum.
REQ-015 SHALL have port overflow, output, 1 bit: the held row overflowed ACC_WIDTH.

Function
REQ-016 SHALL accept a beat on a rising edge where in_valid and in_ready are both high.
REQ-017 SHALL drive in_ready high only in state ACCUM.
REQ-018 SHALL implement states ACCUM, DRAIN and HOLD, entering ACCUM after reset.
REQ-019 SHALL transition ACCUM->DRAIN on acceptance of beat BEATS_PER_ROW-1 (beat counter 0-based), DRAIN->HOLD unconditionally, and HOLD->ACCUM when out_ready is high.
REQ-020 SHALL zero-extend the four lanes, sum them, and register the result as beat_sum one cycle after acceptance.
REQ-021 SHALL add beat_sum into the accumulator in the following cycle, giving a two-cycle pipeline.
REQ-022 SHALL assert out_valid exactly 2 cycles after the last beat of a row is accepted, and hold it with row_sum stable until out_ready.
REQ-023 SHALL, on the HOLD->ACCUM transition, clear the accumulator, beat counter and overflow, and allow a new beat to be accepted in the next cycle.
REQ-024 SHALL, when clear is high, return to ACCUM and zero the counter, accumulator, pipeline and out_valid on the next edge; clear SHALL take priority over in_valid and out_ready in the same cycle.
REQ-025 SHALL ignore in_valid when in_ready is low, with no stall of inputs required.
REQ-026 SHALL wrap the beat counter to 0 after each completed row.

Reset
REQ-027 SHALL, while reset_n is low, asynchronously force state=ACCUM, counter=0, beat_sum=0, accumulator=0, row_sum=0, out_valid=0 and overflow=0.
REQ-028 SHALL abandon any row partially accepted at reset, and SHALL drive in_ready high in the first cycle after reset release.

Configuration
REQ-029 SHALL, with EXP_SUM_SATURATE_EN defined, clamp the accumulator at all-ones when an add would exceed ACC_WIDTH, and set overflow.
REQ-030 SHALL, without EXP_SUM_SATURATE_EN, let the accumulator wrap modulo 2^ACC_WIDTH, with overflow still set on carry-out.

Structure
REQ-031 SHALL take NUM, DATAWIDTH, BEATS_PER_ROW, ACC_WIDTH defaults and the state encoding from the shared package mode7_pkg.
REQ-032 SHALL instantiate one sub-module, exp_sum_tree: a combinational 4-lane adder producing DATAWIDTH+2 bits.

Verification
REQ-033 SHALL cover: 8 beats, all lanes 0x1000 -> row_sum=0x020000 (32.0), out_valid 2 cycles after beat 8, overflow=0.
REQ-034 SHALL cover: out_ready held low for 5 cycles -> row_sum and out_valid stable, in_ready=0; out_ready=1 -> in_ready=1 on the next cycle.
REQ-035 SHALL cover: clear asserted after beat 3 with in_valid=1 -> that beat is dropped, and the next 8 beats of 0x0001 give row_sum=0x000020.
REQ-036 SHALL cover: ACC_WIDTH=18, all lanes 0xFFFF -> with EXP_SUM_SATURATE_EN, row_sum=0x3FFFF and overflow=1; without it, the value wraps modulo 2^18 and overflow=1.
REQ-037 SHALL cover: reset_n pulsed low mid-row and mid-HOLD -> all outputs are 0 immediately (asynchronously), and the next row sums from zero.
REQ-038 SHALL cover: two back-to-back rows with out_ready tied high -> in_ready low for exactly 3 cycles between rows, and both sums are correct.

Source files
------------

// File: rtl/mode7_pkg.sv
// mode7_pkg -- shared definitions for the mode7 softmax datapath.
//   Default geometry of the exp-sum stage (lanes, lane width, beats per
//   row, accumulator width), the exp-sum control state encoding and a
//   helper that sizes the beat counter.
package mode7_pkg;

   localparam int NUM_DEF           = 4;   // lanes per beat (four exp outputs)
   localparam int DATAWIDTH_DEF     = 16;  // unsigned Q4.12 lane
   localparam int BEATS_PER_ROW_DEF = 8;   // 32 words / 4 lanes
   localparam int ACC_WIDTH_DEF     = 24;  // Q12.12 accumulator / result

   // ACCUM : accepting beats of the current row
   // DRAIN : last beat is in the two-stage add pipeline
   // HOLD  : row_sum presented, waiting for the consumer
   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } exp_sum_state_e;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mode7_exp_sum_tree.sv
// exp_sum_tree -- combinational four-lane adder.
//   i_l0..i_l3 : DATAWIDTH-bit unsigned lane values
//   o_sum      : OUT_W-bit zero-extended sum (DATAWIDTH+2 for four lanes,
//                wide enough that it can never carry out)
module exp_sum_tree #(
   parameter int DATAWIDTH = 16,
   parameter int OUT_W     = DATAWIDTH + 2
) (
   input  logic [DATAWIDTH-1:0] i_l0,
   input  logic [DATAWIDTH-1:0] i_l1,
   input  logic [DATAWIDTH-1:0] i_l2,
   input  logic [DATAWIDTH-1:0] i_l3,
   output logic [OUT_W-1:0]     o_sum
);

   logic [DATAWIDTH:0] w_s01;
   logic [DATAWIDTH:0] w_s23;

   // Balanced two-level tree keeps the combinational depth at two adders.
   assign w_s01 = {1'b0, i_l0} + {1'b0, i_l1};
   assign w_s23 = {1'b0, i_l2} + {1'b0, i_l3};
   assign o_sum = OUT_W'(w_s01) + OUT_W'(w_s23);

endmodule

// File: rtl/mode7_exp_sum.sv
// mode7_exp_sum -- per-row sum of softmax exp values.
//   Accepts BEATS_PER_ROW beats of four Q4.12 lanes, sums them into a
//   Q12.12 accumulator through a two-stage pipeline (lane tree, then
//   accumulate) and presents the row total with a valid/ready handshake.
//
//   Ports:
//     clk, reset_n   : clock (rising edge), asynchronous active-low reset
//     clear          : synchronous abort of the current row (highest priority)
//     inp0..inp3     : lane values, in_valid qualifies them
//     in_ready       : high only while accumulating a row
//     row_sum        : row total, valid while out_valid
//     out_valid      : row_sum held until out_ready
//     out_ready      : consumer accepts row_sum
//     overflow       : the held row carried out of ACC_WIDTH
//
//   Build option: define EXP_SUM_SATURATE_EN to clamp the accumulator at
//   all-ones on carry-out; otherwise it wraps modulo 2^ACC_WIDTH. overflow
//   is set on carry-out in both builds.
module mode7_exp_sum
   import mode7_pkg::*;
#(
   parameter int NUM           = NUM_DEF,
   parameter int DATAWIDTH     = DATAWIDTH_DEF,
   parameter int BEATS_PER_ROW = BEATS_PER_ROW_DEF,
   parameter int ACC_WIDTH     = ACC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic [DATAWIDTH-1:0] inp0,
   input  logic [DATAWIDTH-1:0] inp1,
   input  logic [DATAWIDTH-1:0] inp2,
   input  logic [DATAWIDTH-1:0] inp3,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [ACC_WIDTH-1:0] row_sum,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overflow
);

   localparam int TREE_W = DATAWIDTH + $clog2(NUM);
   localparam int CNT_W  = cnt_width(BEATS_PER_ROW);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_ROW - 1);

   exp_sum_state_e       r_state;
   exp_sum_state_e       w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [TREE_W-1:0]    r_beat_sum;
   logic                 r_bs_vld;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_acc_ovf;
   logic [ACC_WIDTH-1:0] r_row_sum;
   logic                 r_out_valid;
   logic                 r_overflow;

   logic [TREE_W-1:0]    w_tree_sum;
   logic [ACC_WIDTH:0]   w_sum_ext;
   logic                 w_carry;
   logic [ACC_WIDTH-1:0] w_acc_next;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_release;

   exp_sum_tree #(
      .DATAWIDTH (DATAWIDTH),
      .OUT_W     (TREE_W)
   ) u_tree (
      .i_l0  (inp0),
      .i_l1  (inp1),
      .i_l2  (inp2),
      .i_l3  (inp3),
      .o_sum (w_tree_sum)
   );

   assign in_ready  = (r_state == ACCUM);
   // clear wins over a beat offered in the same cycle.
   assign w_accept  = in_valid && in_ready && !clear;
   assign w_last    = w_accept && (r_cnt == LAST_BEAT);
   // Leave HOLD only once the result has actually been presented.
   assign w_release = (r_state == HOLD) && r_out_valid && out_ready;

   // One extra bit captures the carry used for overflow / saturation.
   assign w_sum_ext = {1'b0, r_acc} + (ACC_WIDTH+1)'(r_beat_sum);
   assign w_carry   = w_sum_ext[ACC_WIDTH];

`ifdef EXP_SUM_SATURATE_EN
   assign w_acc_next = w_carry ? '1 : w_sum_ext[ACC_WIDTH-1:0];
`else
   assign w_acc_next = w_sum_ext[ACC_WIDTH-1:0];
`endif

   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = ACCUM;
      end else begin
         case (r_state)
            ACCUM:   if (w_last)    w_next = DRAIN;
            DRAIN:                  w_next = HOLD;
            HOLD:    if (w_release) w_next = ACCUM;
            default:                w_next = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ACCUM;
      else          r_state <= w_next;
   end

   // Beat counter: 0-based, wraps to 0 after the last beat of a row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (clear || w_release) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // Stage 1: registered lane sum of the accepted beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_beat_sum <= '0;
         r_bs_vld   <= 1'b0;
      end else if (clear) begin
         r_beat_sum <= '0;
         r_bs_vld   <= 1'b0;
      end else begin
         r_bs_vld <= w_accept;
         if (w_accept) r_beat_sum <= w_tree_sum;
      end
   end

   // Stage 2: accumulate; overflow is sticky for the row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc     <= '0;
         r_acc_ovf <= 1'b0;
      end else if (clear || w_release) begin
         r_acc     <= '0;
         r_acc_ovf <= 1'b0;
      end else if (r_bs_vld) begin
         r_acc     <= w_acc_next;
         r_acc_ovf <= r_acc_ovf || w_carry;
      end
   end

   // Result register: loaded on the first HOLD cycle, when the last beat
   // has been folded into the accumulator.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_row_sum   <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (clear || w_release) begin
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else if ((r_state == HOLD) && !r_out_valid) begin
         r_row_sum   <= r_acc;
         r_out_valid <= 1'b1;
         r_overflow  <= r_acc_ovf;
      end
   end

   assign row_sum   = r_row_sum;
   assign out_valid = r_out_valid;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_mode7_exp_sum.sv
module tb_mode7_exp_sum;

   localparam int BEATS = 8;
   localparam int DW    = 16;
   localparam int AW    = 24;
   localparam int AW18  = 18;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] inp0 = '0, inp1 = '0, inp2 = '0, inp3 = '0;

   logic            in_ready, out_valid, overflow;
   logic [AW-1:0]   row_sum;
   logic            in_ready18, out_valid18, overflow18;
   logic [AW18-1:0] row_sum18;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] lanes [BEATS][4];
   longint        got_q[$];

   mode7_exp_sum dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
      .in_valid(in_valid), .in_ready(in_ready),
      .row_sum(row_sum), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow)
   );

   mode7_exp_sum #(.ACC_WIDTH(AW18)) dut18 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
      .in_valid(in_valid), .in_ready(in_ready18),
      .row_sum(row_sum18), .out_valid(out_valid18), .out_ready(out_ready),
      .overflow(overflow18)
   );

   always #5 clk = ~clk;

   // Records every row total handed over to the consumer.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) got_q.push_back(longint'(row_sum));
   end

   // Reference: running sum of all lanes of the row, beat by beat, in a
   // w-bit accumulator.
   function automatic void model_row(input int w, output longint sum, output bit ovf);
      longint acc = 0;
      longint lim = longint'(1) << w;
      ovf = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         for (int l = 0; l < 4; l++) acc += longint'(lanes[b][l]);
         if (acc >= lim) begin
            ovf = 1'b1;
`ifdef EXP_SUM_SATURATE_EN
            acc = lim - 1;
`else
            acc = acc - lim;
`endif
         end
      end
      sum = acc;
   endfunction

   task automatic fill_const(input logic [DW-1:0] v);
      for (int b = 0; b < BEATS; b++)
         for (int l = 0; l < 4; l++) lanes[b][l] = v;
   endtask

   task automatic fill_rand();
      for (int b = 0; b < BEATS; b++)
         for (int l = 0; l < 4; l++) lanes[b][l] = DW'($urandom);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Offers beat b (after 'gap' idle cycles) and waits until it is taken.
   task automatic send_beat(input int b, input int gap);
      int t = 0;
      in_valid = 1'b0;
      repeat (gap) tick();
      inp0 = lanes[b][0]; inp1 = lanes[b][1]; inp2 = lanes[b][2]; inp3 = lanes[b][3];
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin tick(); t++; end
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_row(input int maxgap);
      for (int b = 0; b < BEATS; b++) send_beat(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic wait_out(output bit ok);
      int t = 0;
      while (!out_valid && t < 50) begin tick(); t++; end
      ok = out_valid;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if (row_sum !== '0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: row_sum=%h out_valid=%b overflow=%b required 0/0/0", row_sum, out_valid, overflow);
      end
      tick(); tick();
      reset_n = 1'b1;
      tick();
      n_chk++;
      if (in_ready !== 1'b1 || in_ready18 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b/%b required 1/1", in_ready, in_ready18);
      end
   endtask

   task automatic test_basic();
      longint exp_s; bit exp_o;
      fill_const(16'h1000);
      model_row(AW, exp_s, exp_o);
      send_row(0);
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat0: out_valid=%b required 0", out_valid); end
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: out_valid=%b required 0", out_valid); end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || longint'(row_sum) != exp_s || overflow !== exp_o) begin
         n_fail++;
         $display("FAIL basic_sum: valid=%b sum=%h ovf=%b required 1/%h/%b", out_valid, row_sum, overflow, exp_s, exp_o);
      end
      n_chk++;
      if (row_sum !== 24'h020000) begin n_fail++; $display("FAIL basic_const: sum=%h required 020000", row_sum); end
      ack();
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_hold();
      longint exp_s; bit exp_o; bit ok;
      fill_rand();
      model_row(AW, exp_s, exp_o);
      send_row(2);
      wait_out(ok);
      n_chk++;
      if (!ok || longint'(row_sum) != exp_s) begin
         n_fail++;
         $display("FAIL hold_sum: valid=%b sum=%h required 1/%h", out_valid, row_sum, exp_s);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++;
         if (out_valid !== 1'b1 || longint'(row_sum) != exp_s || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable%0d: valid=%b sum=%h in_ready=%b required 1/%h/0", i, out_valid, row_sum, in_ready, exp_s);
         end
      end
      ack();
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: in_ready=%b required 1", in_ready); end
   endtask

   task automatic test_clear();
      longint exp_s; bit exp_o; bit ok;
      fill_rand();
      for (int b = 0; b < 3; b++) send_beat(b, 0);
      inp0 = 16'hFFFF; inp1 = 16'hFFFF; inp2 = 16'hFFFF; inp3 = 16'hFFFF;
      in_valid = 1'b1; clear = 1'b1;
      tick();
      in_valid = 1'b0; clear = 1'b0;
      n_chk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_state: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
      fill_const(16'h0001);
      model_row(AW, exp_s, exp_o);
      send_row(0);
      wait_out(ok);
      n_chk++;
      if (!ok || longint'(row_sum) != exp_s || row_sum !== 24'h000020) begin
         n_fail++;
         $display("FAIL clear_sum: valid=%b sum=%h required 1/%h", out_valid, row_sum, exp_s);
      end
      ack();
   endtask

   task automatic test_overflow();
      longint exp18, exp24; bit ovf18, ovf24; bit ok;
      fill_const(16'hFFFF);
      model_row(AW18, exp18, ovf18);
      model_row(AW, exp24, ovf24);
      send_row(1);
      wait_out(ok);
      n_chk++;
      if (!ok || out_valid18 !== 1'b1 || longint'(row_sum18) != exp18 || overflow18 !== ovf18) begin
         n_fail++;
         $display("FAIL ovf18: valid=%b sum=%h ovf=%b required 1/%h/%b", out_valid18, row_sum18, overflow18, exp18, ovf18);
      end
      n_chk++;
      if (overflow18 !== 1'b1) begin n_fail++; $display("FAIL ovf18_flag: ovf=%b required 1", overflow18); end
      n_chk++;
      if (longint'(row_sum) != exp24 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf24: sum=%h ovf=%b required %h/0", row_sum, overflow, exp24);
      end
      ack();
      n_chk++;
      if (overflow18 !== 1'b0 || out_valid18 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf18_release: ovf=%b valid=%b required 0/0", overflow18, out_valid18);
      end
   endtask

   task automatic test_async_reset();
      longint exp_s; bit exp_o; bit ok;
      // Mid-row: the previous row_sum is still held and must vanish.
      fill_rand();
      for (int b = 0; b < 3; b++) send_beat(b, 0);
      #2 reset_n = 1'b0;
      #1;
      n_chk++;
      if (row_sum !== '0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_row: sum=%h valid=%b ovf=%b required 0/0/0", row_sum, out_valid, overflow);
      end
      #1 reset_n = 1'b1;
      tick();
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: in_ready=%b required 1", in_ready); end
      fill_rand();
      model_row(AW, exp_s, exp_o);
      send_row(0);
      wait_out(ok);
      n_chk++;
      if (!ok || longint'(row_sum) != exp_s) begin
         n_fail++;
         $display("FAIL areset_sum1: sum=%h required %h", row_sum, exp_s);
      end
      // Mid-HOLD.
      #2 reset_n = 1'b0;
      #1;
      n_chk++;
      if (row_sum !== '0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_hold: sum=%h valid=%b ovf=%b required 0/0/0", row_sum, out_valid, overflow);
      end
      #1 reset_n = 1'b1;
      tick();
      fill_rand();
      model_row(AW, exp_s, exp_o);
      send_row(1);
      wait_out(ok);
      n_chk++;
      if (!ok || longint'(row_sum) != exp_s) begin
         n_fail++;
         $display("FAIL areset_sum2: sum=%h required %h", row_sum, exp_s);
      end
      ack();
   endtask

   task automatic test_back_to_back();
      longint expa, expb; bit oa, ob;
      int low = 0;
      int t = 0;
      got_q.delete();
      out_ready = 1'b1;
      fill_rand();
      model_row(AW, expa, oa);
      send_row(0);
      while (!in_ready && t < 20) begin low++; tick(); t++; end
      n_chk++;
      if (low != 3) begin n_fail++; $display("FAIL b2b_gap: in_ready low %0d cycles required 3", low); end
      fill_rand();
      model_row(AW, expb, ob);
      send_row(0);
      t = 0;
      while (got_q.size() < 2 && t < 20) begin tick(); t++; end
      n_chk++;
      if (got_q.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count: rows %0d required 2", got_q.size());
      end else begin
         n_chk++;
         if (got_q[0] != expa || got_q[1] != expb) begin
            n_fail++;
            $display("FAIL b2b_sums: got %h %h required %h %h", got_q[0], got_q[1], expa, expb);
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      longint exp_q[$];
      longint e; bit o; bit ok;
      int t = 0;
      got_q.delete();
      for (int r = 0; r < 5; r++) begin
         fill_rand();
         model_row(AW, e, o);
         exp_q.push_back(e);
         send_row(3);
         wait_out(ok);
         n_chk++;
         if (!ok || overflow !== o) begin
            n_fail++;
            $display("FAIL rand_valid%0d: valid=%b ovf=%b required 1/%b", r, out_valid, overflow, o);
         end
         repeat ($urandom_range(0, 4)) tick();
         ack();
      end
      while (got_q.size() < 5 && t < 10) begin tick(); t++; end
      n_chk++;
      if (got_q.size() != 5) begin
         n_fail++;
         $display("FAIL rand_count: rows %0d required 5", got_q.size());
      end else begin
         for (int r = 0; r < 5; r++) begin
            n_chk++;
            if (got_q[r] != exp_q[r]) begin
               n_fail++;
               $display("FAIL rand_sum%0d: got %h required %h", r, got_q[r], exp_q[r]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_clear();
      test_overflow();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
